eth_tx_frame_arbiter: RTL and testbench
=======================================

# eth_tx_frame_arbiter

Frame-granular round-robin arbiter that shares the single 32-bit AXI-Stream TX path toward the Ethernet MAC framer among `NUM_SRC` frame producers (for example the ARP responder, the ICMP echo path and the UDP transmit buffer). A grant is held from the first beat to the `tlast` beat of one frame, so frames are never interleaved. A per-grant stall watchdog terminates a frame whose source stops supplying data. It emits an error-marked `tlast` beat downstream and then silently drains the rest of the offending source's frame.

## Interface
- `NUM_SRC`, default 3: number of requesting sources, 2..8.
- `DATA_WIDTH`, default 32: AXI-Stream data width.
- `TIMEOUT`, default 255: consecutive stall cycles that trigger an abort, 1..65535.
- `aclk` in 1: the single clock. Everything in the block is synchronous to it.
- `areset` in 1: reset is synchronous and active-high.
- `s_axis_tdata` in `NUM_SRC*DATA_WIDTH`: source data. Source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `s_axis_tvalid` in `NUM_SRC`: per-source valid.
- `s_axis_tlast` in `NUM_SRC`: per-source end of frame.
- `s_axis_tready` out `NUM_SRC`: per-source ready.
- `m_axis_tdata` out `DATA_WIDTH`: data to the MAC framer.
- `m_axis_tvalid` out 1: valid to the MAC framer.
- `m_axis_tlast` out 1: end of frame to the MAC framer.
- `m_axis_tuser` out 1: set together with `tlast` on an aborted frame.
- `m_axis_tready` in 1: ready from the MAC framer.
- `grant_id` out `$clog2(NUM_SRC)`: index of the currently granted source.
- `busy` out 1: high in every state other than IDLE.
- `abort_cnt` out 16: saturating count of aborted frames.

## Operation
- FSM states: IDLE, XFER, ABORT, DRAIN. Reset enters IDLE.
- IDLE
  - All `s_axis_tready`=0 and `m_axis_tvalid`=0.
  - When any `s_axis_tvalid` bit is set, grant the first requesting index at or after `rr_ptr`, wrapping modulo `NUM_SRC`.
  - Register the winner into `grant_id`, clear the stall counter, and go to XFER.
- XFER (combinational pass-through of the granted source g)
  - `m_axis_tdata/tvalid/tlast` equal source g's `tdata/tvalid/tlast`.
  - `m_axis_tuser`=0.
  - `s_axis_tready[g]` equals `m_axis_tready`. Every other ready is 0.
  - A handshake with `s_axis_tlast[g]`=1 ends the frame: set `rr_ptr` = (g+1) mod `NUM_SRC` and go to IDLE.
  - Stall counter (16 bits):
    - Increments on each cycle with `s_axis_tvalid[g]`=0.
    - Clears on any cycle with `s_axis_tvalid[g]`=1.
    - Downstream backpressure (source valid, sink not ready) is not a stall.
  - When the counter reaches `TIMEOUT`, go to ABORT on the next edge.
- ABORT
  - Drive `m_axis_tvalid`=1, `tlast`=1, `tuser`=1, `tdata`=0. All source readies are 0.
  - On `m_axis_tready`: increment `abort_cnt` (saturating at 0xFFFF) and go to DRAIN.
- DRAIN
  - `m_axis_tvalid`=0. `s_axis_tready[g]`=1.
  - Accept and discard source g's beats until a beat with `s_axis_tlast[g]`=1.
  - Then set `rr_ptr`=(g+1) mod `NUM_SRC` and go to IDLE.
  - DRAIN has no timeout. A source that never sends `tlast` keeps the arbiter in DRAIN.
- Requests from sources other than g are ignored while a grant is held. They are never dropped: sources hold `tvalid` per AXI-Stream rules.
- A request that rises in the same cycle as a frame-ending handshake is arbitrated in the following IDLE cycle.
- Reset mid-frame:
  - State returns to IDLE. `rr_ptr`=0, `grant_id`=0, `abort_cnt`=0.
  - Any partial frame downstream is the MAC framer's concern. This block emits no closing beat.

## Timing
- Reset values:
  - `m_axis_tvalid`=0, `m_axis_tlast`=0, `m_axis_tuser`=0, `m_axis_tdata`=0.
  - `s_axis_tready`=0.
  - `grant_id`=0, `busy`=0, `abort_cnt`=0.
- Grant latency: request visible in IDLE at cycle N → XFER at N+1. The first beat can complete at N+1.
- There is exactly one IDLE bubble cycle between consecutive frames, including back-to-back frames from the same source.
- XFER path: zero latency, combinational from source to sink and from `m_axis_tready` to `s_axis_tready[g]`.
- `grant_id`, `busy` and `abort_cnt` are registered.
- Abort timing: the last valid-low cycle that makes the counter equal `TIMEOUT` is cycle M. ABORT begins at M+1 and its beat is presented at M+1.

## Test plan
- Single source, 4-beat frame 0x11..0x44 from source 1, `m_axis_tready`=1:
  - XFER entered 1 cycle after `tvalid`. 4 beats out with `tlast` on 0x44.
  - `rr_ptr`=2 afterwards and `busy` returns to 0.
- All three sources request continuously, 2-beat frames each, after reset:
  - Grant order is 0,1,2,0,1,2.
  - One bubble between frames. No interleaved beats.
- Backpressure: toggle `m_axis_tready` every cycle during a 6-beat frame with `TIMEOUT`=4:
  - No abort. All 6 beats delivered in order.
  - `s_axis_tready[g]` mirrors `m_axis_tready`.
- Stall abort, `TIMEOUT`=4: source 0 sends 2 beats and then drops `tvalid` for 4 cycles:
  - Next cycle the sink sees a beat with `tdata`=0, `tlast`=1, `tuser`=1.
  - `abort_cnt`=1.
  - The source's remaining 3 beats are accepted in DRAIN with `m_axis_tvalid`=0.
  - The next grant goes to source 1.
- Reset asserted mid-frame at beat 3 of 8:
  - The following cycle `busy`=0, `s_axis_tready`=0, `m_axis_tvalid`=0.
  - The next grant goes to the lowest requesting index.

Source files
------------

// File: rtl/eth_tx_frame_arbiter.sv
// Frame-granular round-robin arbiter for the Ethernet TX AXI-Stream path, with a
// per-grant stall watchdog that aborts a stuck frame and drains its remainder.
module eth_tx_frame_arbiter #(
    parameter int NUM_SRC    = 3,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_SRC-1:0]            s_axis_tvalid,
    input  logic [NUM_SRC-1:0]            s_axis_tlast,
    output logic [NUM_SRC-1:0]            s_axis_tready,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic                          m_axis_tvalid,
    output logic                          m_axis_tlast,
    output logic                          m_axis_tuser,
    input  logic                          m_axis_tready,
    output logic [$clog2(NUM_SRC)-1:0]    grant_id,
    output logic                          busy,
    output logic [15:0]                   abort_cnt
);

    // A beat moves on every cycle where valid and ready are both high; valid never
    // waits on ready, and a source holds tvalid/tdata/tlast stable until accepted.

    localparam int GW = $clog2(NUM_SRC);
    localparam logic [15:0] STALL_LIM = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, XFER, ABORT, DRAIN} state_t;

    state_t                state;
    logic [GW-1:0]         rr_ptr;
    logic [15:0]           stall_cnt;
    logic [GW-1:0]         pick;
    logic [GW-1:0]         nxt_ptr;
    logic [DATA_WIDTH-1:0] g_data;
    logic                  g_valid;
    logic                  g_last;

    // Walk the offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        pick = rr_ptr;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (s_axis_tvalid[(int'(rr_ptr) + k) % NUM_SRC]) begin
                pick = GW'((int'(rr_ptr) + k) % NUM_SRC);
            end
        end
    end

    always_comb begin
        g_data  = '0;
        g_valid = 1'b0;
        g_last  = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant_id == GW'(i)) begin
                g_data  = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
                g_valid = s_axis_tvalid[i];
                g_last  = s_axis_tlast[i];
            end
        end
    end

    assign nxt_ptr = (grant_id == GW'(NUM_SRC - 1)) ? '0 : grant_id + 1'b1;

    always_comb begin
        m_axis_tdata  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tuser  = 1'b0;
        s_axis_tready = '0;
        case (state)
            XFER: begin
                m_axis_tdata            = g_data;
                m_axis_tvalid           = g_valid;
                m_axis_tlast            = g_last;
                s_axis_tready[grant_id] = m_axis_tready;
            end
            ABORT: begin
                m_axis_tvalid = 1'b1;
                m_axis_tlast  = 1'b1;
                m_axis_tuser  = 1'b1;
            end
            DRAIN: s_axis_tready[grant_id] = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            grant_id  <= '0;
            stall_cnt <= '0;
            abort_cnt <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|s_axis_tvalid) begin
                        grant_id  <= pick;
                        stall_cnt <= '0;
                        state     <= XFER;
                        busy      <= 1'b1;
                    end
                end
                XFER: begin
                    // Only a missing source beat is a stall; sink backpressure is not.
                    if (g_valid) begin
                        stall_cnt <= '0;
                        if (m_axis_tready && g_last) begin
                            rr_ptr <= nxt_ptr;
                            state  <= IDLE;
                            busy   <= 1'b0;
                        end
                    end else begin
                        stall_cnt <= stall_cnt + 1'b1;
                        if (stall_cnt == STALL_LIM) begin
                            state <= ABORT;
                        end
                    end
                end
                ABORT: begin
                    if (m_axis_tready) begin
                        if (abort_cnt != 16'hFFFF) begin
                            abort_cnt <= abort_cnt + 16'd1;
                        end
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (g_valid && g_last) begin
                        rr_ptr <= nxt_ptr;
                        state  <= IDLE;
                        busy   <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eth_tx_frame_arbiter.sv
// Self-checking bench for eth_tx_frame_arbiter: arbitration vector table, directed
// frame/abort/reset sequences, and a randomized multi-source run against a frame model.
module tb_eth_tx_frame_arbiter;

    localparam int NS = 3;
    localparam int DW = 32;
    localparam int TO = 4;
    localparam int GW = 2;
    localparam int W  = 35;  // {src[1:0], last, data[31:0]}

    logic             aclk = 1'b0;
    logic             areset;
    logic [NS*DW-1:0] s_axis_tdata;
    logic [NS-1:0]    s_axis_tvalid;
    logic [NS-1:0]    s_axis_tlast;
    logic [NS-1:0]    s_axis_tready;
    logic [DW-1:0]    m_axis_tdata;
    logic             m_axis_tvalid;
    logic             m_axis_tlast;
    logic             m_axis_tuser;
    logic             m_axis_tready;
    logic [GW-1:0]    grant_id;
    logic             busy;
    logic [15:0]      abort_cnt;

    int n_cmp = 0;
    int n_err = 0;
    logic [W-1:0] exp_q[$];

    eth_tx_frame_arbiter #(.NUM_SRC(NS), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .aclk(aclk), .areset(areset),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
        .m_axis_tready(m_axis_tready),
        .grant_id(grant_id), .busy(busy), .abort_cnt(abort_cnt)
    );

    // ---------------- clock / reset ----------------
    always #5 aclk = ~aclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge aclk);
        areset        = 1'b1;
        s_axis_tvalid = '0;
        s_axis_tlast  = '0;
        s_axis_tdata  = '0;
        m_axis_tready = 1'b0;
        @(negedge aclk);
        @(negedge aclk);
        areset = 1'b0;
    endtask

    // ---------------- driver ----------------
    task automatic drive_src(input int i, input logic v, input logic [DW-1:0] d, input logic l);
        s_axis_tvalid[i]        = v;
        s_axis_tdata[i*DW +: DW] = d;
        s_axis_tlast[i]         = l;
    endtask

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        int            prime;      // source of a 1-beat frame sent first (-1: none)
        logic [NS-1:0] req;
        logic [GW-1:0] exp_grant;
        logic [DW-1:0] exp_data;
    } arb_vec_t;

    arb_vec_t vecs[10];

    int            src_len[NS];
    int            src_idx[NS];
    int            gap[NS];
    logic [DW-1:0] src_d[NS][64];
    logic          src_l[NS][64];

    initial begin
        logic [W-1:0]  e;
        logic [NS-1:0] popped;
        logic [DW-1:0] d;
        int            b;
        int            cyc;
        int            len;

        vecs[0] = '{-1, 3'b001, 2'd0, 32'hA0};
        vecs[1] = '{-1, 3'b110, 2'd1, 32'hA1};
        vecs[2] = '{-1, 3'b100, 2'd2, 32'hA2};
        vecs[3] = '{-1, 3'b111, 2'd0, 32'hA0};
        vecs[4] = '{ 0, 3'b111, 2'd1, 32'hA1};
        vecs[5] = '{ 1, 3'b111, 2'd2, 32'hA2};
        vecs[6] = '{ 2, 3'b111, 2'd0, 32'hA0};
        vecs[7] = '{ 1, 3'b011, 2'd0, 32'hA0};
        vecs[8] = '{ 2, 3'b110, 2'd1, 32'hA1};
        vecs[9] = '{ 0, 3'b101, 2'd2, 32'hA2};

        areset        = 1'b1;
        s_axis_tvalid = '0;
        s_axis_tlast  = '0;
        s_axis_tdata  = '0;
        m_axis_tready = 1'b0;

        // Reset values
        @(negedge aclk);
        @(negedge aclk);
        chk("rst m_tvalid", m_axis_tvalid, 0);
        chk("rst m_tlast", m_axis_tlast, 0);
        chk("rst m_tuser", m_axis_tuser, 0);
        chk("rst m_tdata", m_axis_tdata, 0);
        chk("rst s_tready", s_axis_tready, 0);
        chk("rst grant_id", grant_id, 0);
        chk("rst busy", busy, 0);
        chk("rst abort_cnt", abort_cnt, 0);

        // Arbitration vector table
        for (int k = 0; k < 10; k++) begin
            do_reset();
            if (vecs[k].prime >= 0) begin
                drive_src(vecs[k].prime, 1'b1, 32'hC0, 1'b1);
                m_axis_tready = 1'b1;
                @(negedge aclk);
                @(negedge aclk);
                drive_src(vecs[k].prime, 1'b0, '0, 1'b0);
            end
            for (int i = 0; i < NS; i++) drive_src(i, vecs[k].req[i], DW'(32'hA0 + i), 1'b1);
            m_axis_tready = 1'b0;
            #1;
            chk($sformatf("vec%0d idle m_tvalid", k), m_axis_tvalid, 0);
            chk($sformatf("vec%0d idle s_tready", k), s_axis_tready, 0);
            @(negedge aclk);
            #1;
            chk($sformatf("vec%0d grant", k), grant_id, vecs[k].exp_grant);
            chk($sformatf("vec%0d busy", k), busy, 1);
            chk($sformatf("vec%0d m_tvalid", k), m_axis_tvalid, 1);
            chk($sformatf("vec%0d m_tdata", k), m_axis_tdata, vecs[k].exp_data);
        end

        // Single source 4-beat frame from source 1
        do_reset();
        drive_src(1, 1'b1, 32'h11, 1'b0);
        m_axis_tready = 1'b1;
        @(negedge aclk);
        chk("single busy", busy, 1);
        chk("single grant", grant_id, 1);
        for (int bb = 0; bb < 4; bb++) begin
            d = DW'((bb + 1) * 17);
            drive_src(1, 1'b1, d, bb == 3);
            #1;
            chk($sformatf("single b%0d tvalid", bb), m_axis_tvalid, 1);
            chk($sformatf("single b%0d tdata", bb), m_axis_tdata, d);
            chk($sformatf("single b%0d tlast", bb), m_axis_tlast, bb == 3);
            chk($sformatf("single b%0d s_tready", bb), s_axis_tready, 3'b010);
            @(negedge aclk);
        end
        drive_src(1, 1'b0, '0, 1'b0);
        #1;
        chk("single busy after", busy, 0);
        for (int i = 0; i < NS; i++) drive_src(i, 1'b1, DW'(32'hA0 + i), 1'b1);
        @(negedge aclk);
        chk("single rr_ptr=2", grant_id, 2);

        // Backpressure: long sink stall, then toggling ready, 6-beat frame
        do_reset();
        drive_src(0, 1'b1, 32'h60, 1'b0);
        @(negedge aclk);
        b   = 0;
        cyc = 0;
        while (b < 6 && cyc < 40) begin
            m_axis_tready = (cyc < 5) ? 1'b0 : cyc[0];
            drive_src(0, 1'b1, DW'(32'h60 + b), b == 5);
            #1;
            chk("bp s_tready mirror", s_axis_tready, {2'b00, m_axis_tready});
            chk("bp m_tvalid", m_axis_tvalid, 1);
            if (m_axis_tready) begin
                chk("bp tdata", m_axis_tdata, DW'(32'h60 + b));
                b++;
            end
            @(negedge aclk);
            cyc++;
        end
        drive_src(0, 1'b0, '0, 1'b0);
        chk("bp beats delivered", b, 6);
        chk("bp no abort", abort_cnt, 0);
        #1;
        chk("bp busy after", busy, 0);

        // Stall abort with TIMEOUT=4
        do_reset();
        drive_src(0, 1'b1, 32'h01, 1'b0);
        drive_src(1, 1'b1, 32'hB1, 1'b1);
        m_axis_tready = 1'b1;
        @(negedge aclk);
        #1;
        chk("abort grant0", grant_id, 0);
        @(negedge aclk);
        drive_src(0, 1'b1, 32'h02, 1'b0);
        @(negedge aclk);
        drive_src(0, 1'b0, '0, 1'b0);
        for (int c = 0; c < 4; c++) begin
            #1;
            chk($sformatf("abort stall%0d m_tvalid", c), m_axis_tvalid, 0);
            chk($sformatf("abort stall%0d busy", c), busy, 1);
            @(negedge aclk);
        end
        #1;
        chk("abort beat tvalid", m_axis_tvalid, 1);
        chk("abort beat tlast", m_axis_tlast, 1);
        chk("abort beat tuser", m_axis_tuser, 1);
        chk("abort beat tdata", m_axis_tdata, 0);
        chk("abort beat s_tready", s_axis_tready, 0);
        @(negedge aclk);
        chk("abort_cnt", abort_cnt, 1);
        for (int bb = 0; bb < 3; bb++) begin
            drive_src(0, 1'b1, DW'(32'hD0 + bb), bb == 2);
            #1;
            chk($sformatf("drain b%0d m_tvalid", bb), m_axis_tvalid, 0);
            chk($sformatf("drain b%0d s_tready", bb), s_axis_tready, 3'b001);
            @(negedge aclk);
        end
        drive_src(0, 1'b0, '0, 1'b0);
        #1;
        chk("drain busy after", busy, 0);
        @(negedge aclk);
        #1;
        chk("abort next grant", grant_id, 1);
        chk("abort next tdata", m_axis_tdata, 32'hB1);
        chk("abort next tuser", m_axis_tuser, 0);
        @(negedge aclk);
        drive_src(1, 1'b0, '0, 1'b0);

        // Reset in the middle of an 8-beat frame
        do_reset();
        m_axis_tready = 1'b1;
        drive_src(2, 1'b1, 32'h80, 1'b0);
        @(negedge aclk);
        #1;
        chk("midrst grant2", grant_id, 2);
        @(negedge aclk);
        drive_src(2, 1'b1, 32'h81, 1'b0);
        @(negedge aclk);
        drive_src(2, 1'b1, 32'h82, 1'b0);
        drive_src(1, 1'b1, 32'h91, 1'b1);
        areset = 1'b1;
        @(negedge aclk);
        #1;
        chk("midrst busy", busy, 0);
        chk("midrst s_tready", s_axis_tready, 0);
        chk("midrst m_tvalid", m_axis_tvalid, 0);
        chk("midrst grant_id", grant_id, 0);
        areset = 1'b0;
        @(negedge aclk);
        #1;
        chk("midrst next grant", grant_id, 1);
        chk("midrst next busy", busy, 1);

        // Randomized run: every source always has a frame ready at its turn, so the
        // frames must leave in strict round-robin order 0,1,2,0,1,2,...
        exp_q.delete();
        for (int i = 0; i < NS; i++) begin
            src_len[i] = 0;
            src_idx[i] = 0;
            gap[i]     = 0;
        end
        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < NS; i++) begin
                len = $urandom_range(1, 5);
                for (int bb = 0; bb < len; bb++) begin
                    d = $urandom;
                    src_d[i][src_len[i]] = d;
                    src_l[i][src_len[i]] = (bb == len - 1);
                    exp_q.push_back({2'(i), bb == len - 1, d});
                    src_len[i]++;
                end
            end
        end
        do_reset();
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 3000) begin
            for (int i = 0; i < NS; i++) begin
                if (src_idx[i] < src_len[i] && gap[i] == 0)
                    drive_src(i, 1'b1, src_d[i][src_idx[i]], src_l[i][src_idx[i]]);
                else
                    drive_src(i, 1'b0, '0, 1'b0);
            end
            m_axis_tready = ($urandom_range(0, 3) != 0);
            #1;
            popped = s_axis_tvalid & s_axis_tready;
            if (m_axis_tvalid && m_axis_tready) begin
                e = exp_q.pop_front();
                chk("rnd tdata", m_axis_tdata, e[31:0]);
                chk("rnd tlast", m_axis_tlast, e[32]);
                chk("rnd tuser", m_axis_tuser, 0);
                chk("rnd grant", grant_id, e[34:33]);
                chk("rnd source pop", popped, 3'b001 << e[34:33]);
            end else begin
                chk("rnd no pop", popped, 0);
            end
            @(posedge aclk);
            for (int i = 0; i < NS; i++) begin
                if (popped[i]) begin
                    if (!src_l[i][src_idx[i]] && $urandom_range(0, 2) == 0)
                        gap[i] = $urandom_range(1, 2);
                    src_idx[i]++;
                end else if (gap[i] > 0) begin
                    gap[i]--;
                end
            end
            @(negedge aclk);
            cyc++;
        end
        chk("rnd frames left", exp_q.size(), 0);
        chk("rnd abort_cnt", abort_cnt, 0);

        // ---------------- report ----------------
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
